// File: rtl/block_interleaver.sv
// ---------------------------------------------------------------------------
// block_interleaver
//
// Ping-pong block interleaver for 32-bit AXI4-Stream data. Collects
// NUM_CODEWORDS codewords of CODEWORD_SIZE_IN_32 words each into one bank,
// then emits the block column-wise: word j of every codeword in turn.
// While one bank drains, the other bank fills.
//
// Parameters
//   CODEWORD_SIZE_IN_32 : words per codeword (CW), >= 2
//   NUM_CODEWORDS       : codewords per block (N), >= 2
//
// Ports
//   clk            : clock, all logic on the rising edge
//   rst            : asynchronous active-high reset
//   s_axis_tdata   : input word
//   s_axis_tvalid  : input word valid
//   s_axis_tready  : interleaver can accept a word (registered)
//   m_axis_tdata   : interleaved output word (registered)
//   m_axis_tvalid  : output word valid (registered)
//   m_axis_tready  : downstream accepts the word
//   m_axis_tlast   : last word of a block (only with BLOCK_INTERLEAVER_TLAST_EN)
//
// Configuration macro
//   BLOCK_INTERLEAVER_TLAST_EN : adds the m_axis_tlast output port.
// ---------------------------------------------------------------------------
module block_interleaver #(
    parameter int CODEWORD_SIZE_IN_32 = 65,
    parameter int NUM_CODEWORDS       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready
`ifdef BLOCK_INTERLEAVER_TLAST_EN
    ,
    output logic        m_axis_tlast
`endif
);

    localparam int CW         = CODEWORD_SIZE_IN_32;
    localparam int N          = NUM_CODEWORDS;
    localparam int BLOCK_SIZE = CW * N;
    localparam int AW         = $clog2(2 * BLOCK_SIZE);
    localparam int CW_W       = $clog2(CW);
    localparam int N_W        = $clog2(N);

    localparam logic [AW-1:0]   BS_A   = AW'(BLOCK_SIZE);
    localparam logic [AW-1:0]   LAST_A = AW'(BLOCK_SIZE - 1);
    localparam logic [AW-1:0]   CW_A   = AW'(CW);
    localparam logic [N_W-1:0]  C_LAST = N_W'(N - 1);
    localparam logic [CW_W-1:0] J_LAST = CW_W'(CW - 1);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FILLING,
        ST_FULL,
        ST_DRAINING
    } bank_state_t;

    // ------------------------------------------------------------------
    // Storage: bank 0 at [0, BLOCK_SIZE), bank 1 at [BLOCK_SIZE, 2*BLOCK_SIZE)
    // ------------------------------------------------------------------
    logic [31:0] r_mem [0:2*BLOCK_SIZE-1];

    // Bank state machines
    bank_state_t r_state     [0:1];
    bank_state_t w_state_nxt [0:1];

    // Write side
    logic          r_wbank;
    logic [AW-1:0] r_waddr;
    logic          r_s_tready;
    logic          w_wbank_nxt;
    logic [AW-1:0] w_waddr_nxt;
    logic          w_s_tready_nxt;
    logic          w_wr_hs;
    logic [AW-1:0] w_wr_phys;

    // Read (fetch) side: r_rbank is the bank being fetched, which may run
    // ahead of the bank whose words are still in the output pipeline.
    logic            r_rbank;
    logic [AW-1:0]   r_raddr;
    logic [N_W-1:0]  r_rc;
    logic [CW_W-1:0] r_rj;
    logic            w_rd_ok;
    logic            w_rd_last;
    logic            w_issue;
    logic [AW-1:0]   w_rd_phys;

    // Prefetch stage (registered memory read) and output register
    logic        r_f_vld;
    logic        r_f_last;
    logic        r_f_bank;
    logic [31:0] r_f_data;
    logic        r_m_vld;
    logic        r_m_last;
    logic        r_m_bank;
    logic [31:0] r_m_data;
    logic        w_out_load;
    logic        w_f_take;
    logic        w_out_hs;

    // ------------------------------------------------------------------
    // Handshakes and pipeline advance
    // ------------------------------------------------------------------
    assign w_wr_hs    = s_axis_tvalid && r_s_tready;
    assign w_out_hs   = r_m_vld && m_axis_tready;
    assign w_out_load = !r_m_vld || m_axis_tready;
    assign w_f_take   = !r_f_vld || w_out_load;

    // Fetching may start the cycle a bank turns FULL, so a second FULL bank
    // follows the first with no bubble.
    assign w_rd_ok   = (r_state[r_rbank] == ST_FULL) || (r_state[r_rbank] == ST_DRAINING);
    assign w_issue   = w_rd_ok && w_f_take;
    assign w_rd_last = (r_rc == C_LAST) && (r_rj == J_LAST);

    assign w_wr_phys = r_wbank ? (r_waddr + BS_A) : r_waddr;
    assign w_rd_phys = r_rbank ? (r_raddr + BS_A) : r_raddr;

    // ------------------------------------------------------------------
    // Bank state / write pointer next-state logic
    // The three events touch banks in mutually exclusive states, so they
    // never collide on the same bank and can all be honored together.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_wbank_nxt = r_wbank;
        w_waddr_nxt = r_waddr;

        if (w_wr_hs) begin
            if (r_waddr == LAST_A) begin
                w_state_nxt[r_wbank] = ST_FULL;
                w_wbank_nxt          = ~r_wbank;
                w_waddr_nxt          = '0;
            end else begin
                w_state_nxt[r_wbank] = ST_FILLING;
                w_waddr_nxt          = r_waddr + AW'(1);
            end
        end

        if (w_issue && (r_state[r_rbank] == ST_FULL))
            w_state_nxt[r_rbank] = ST_DRAINING;

        // Bank is released only once its final word leaves the output.
        if (w_out_hs && r_m_last)
            w_state_nxt[r_m_bank] = ST_EMPTY;

        w_s_tready_nxt = (w_state_nxt[w_wbank_nxt] == ST_EMPTY) ||
                         (w_state_nxt[w_wbank_nxt] == ST_FILLING);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state[0] <= ST_EMPTY;
            r_state[1] <= ST_EMPTY;
            r_wbank    <= 1'b0;
            r_waddr    <= '0;
            r_s_tready <= 1'b0;
        end else begin
            r_state[0] <= w_state_nxt[0];
            r_state[1] <= w_state_nxt[1];
            r_wbank    <= w_wbank_nxt;
            r_waddr    <= w_waddr_nxt;
            r_s_tready <= w_s_tready_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Read address generator: addr = c*CW + j, built by stepping CW per
    // codeword and restarting at j+1 when c wraps.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rbank <= 1'b0;
            r_raddr <= '0;
            r_rc    <= '0;
            r_rj    <= '0;
        end else if (w_issue) begin
            if (r_rc == C_LAST) begin
                r_rc <= '0;
                if (w_rd_last) begin
                    r_rj    <= '0;
                    r_raddr <= '0;
                    r_rbank <= ~r_rbank;
                end else begin
                    r_rj    <= r_rj + CW_W'(1);
                    r_raddr <= AW'(r_rj) + AW'(1);
                end
            end else begin
                r_rc    <= r_rc + N_W'(1);
                r_raddr <= r_raddr + CW_A;
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory: write port and registered read port (no reset on storage)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_hs)
            r_mem[w_wr_phys] <= s_axis_tdata;
    end

    always_ff @(posedge clk) begin
        if (w_issue)
            r_f_data <= r_mem[w_rd_phys];
    end

    // ------------------------------------------------------------------
    // Prefetch stage control and output register. The prefetch stage acts
    // as the skid entry: it refills in the same cycle it hands a word on.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_f_vld  <= 1'b0;
            r_f_last <= 1'b0;
            r_f_bank <= 1'b0;
        end else if (w_issue) begin
            r_f_vld  <= 1'b1;
            r_f_last <= w_rd_last;
            r_f_bank <= r_rbank;
        end else if (w_out_load) begin
            r_f_vld  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_vld  <= 1'b0;
            r_m_last <= 1'b0;
            r_m_bank <= 1'b0;
            r_m_data <= '0;
        end else if (w_out_load) begin
            r_m_vld <= r_f_vld;
            if (r_f_vld) begin
                r_m_data <= r_f_data;
                r_m_last <= r_f_last;
                r_m_bank <= r_f_bank;
            end
        end
    end

    assign s_axis_tready = r_s_tready;
    assign m_axis_tvalid = r_m_vld;
    assign m_axis_tdata  = r_m_data;

`ifdef BLOCK_INTERLEAVER_TLAST_EN
    assign m_axis_tlast = r_m_vld && r_m_last;
`endif

endmodule

// File: tb/tb_block_interleaver.sv
// ---------------------------------------------------------------------------
// tb_block_interleaver
//
// Directed self-checking bench for block_interleaver (CW=65, N=4).
// Expected output word i of a block with input base B is
// B + (i mod N)*CW + i/N.
// ---------------------------------------------------------------------------
module tb_block_interleaver;

    localparam int CW = 65;
    localparam int N  = 4;
    localparam int BS = CW * N;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
`ifdef BLOCK_INTERLEAVER_TLAST_EN
    logic        m_axis_tlast;
`endif

    block_interleaver #(
        .CODEWORD_SIZE_IN_32 (CW),
        .NUM_CODEWORDS       (N)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
`ifdef BLOCK_INTERLEAVER_TLAST_EN
        ,
        .m_axis_tlast  (m_axis_tlast)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d exp %0d", tag, got, exp);
        end
    endtask

    int          acc_cnt;
    int          last_hs_cyc;
    int          first_vld_cyc;
    int          last_out_cyc;
    logic [31:0] got_q[$];
    logic        got_last_q[$];

    // Drive n words base..base+n-1; handshake decided at the negedge from the
    // registered tready, which holds until the next rising edge.
    task automatic send(input int base, input int n, input bit gaps);
        int k = 0;
        int budget = 0;
        bit hs = 0;
        while (1) begin
            @(negedge clk);
            if (hs) begin
                k++;
                acc_cnt++;
                if (k == n) last_hs_cyc = cyc;
            end
            if (k == n || budget > 20000) break;
            budget++;
            s_axis_tvalid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_axis_tdata  = base + k;
            hs = s_axis_tvalid && s_axis_tready;
        end
        s_axis_tvalid = 1'b0;
        if (k != n) chk("send_timeout", k, n);
    endtask

    // Collect n output words; bp enables random downstream backpressure and
    // every stalled cycle checks that the output held still.
    task automatic collect(input int n, input bit bp);
        int budget = 0;
        int hold = 0;
        bit rdy = 1'b1;
        bit stalled = 1'b0;
        logic [31:0] prev_d = '0;
        got_q.delete();
        got_last_q.delete();
        first_vld_cyc = -1;
        while (1) begin
            @(negedge clk);
            if (stalled) begin
                chk("hold_vld", m_axis_tvalid, 1);
                chk("hold_data", m_axis_tdata, prev_d);
            end
            if (first_vld_cyc < 0 && m_axis_tvalid) first_vld_cyc = cyc;
            if (got_q.size() == n || budget > 20000) break;
            budget++;
            if (bp) begin
                if (hold == 0) begin
                    rdy  = !rdy;
                    hold = rdy ? $urandom_range(5, 25) : $urandom_range(1, 10);
                end
                hold--;
            end else begin
                rdy = 1'b1;
            end
            m_axis_tready = rdy;
            stalled = m_axis_tvalid && !rdy;
            prev_d  = m_axis_tdata;
            if (m_axis_tvalid && rdy) begin
                got_q.push_back(m_axis_tdata);
`ifdef BLOCK_INTERLEAVER_TLAST_EN
                got_last_q.push_back(m_axis_tlast);
`else
                got_last_q.push_back(1'b0);
`endif
                last_out_cyc = cyc;
            end
        end
        if (got_q.size() != n) chk("collect_timeout", got_q.size(), n);
    endtask

    task automatic check_block(input string tag, input int base, input int blk);
        for (int i = 0; i < BS; i++) begin
            int idx = blk * BS + i;
            logic [31:0] exp = base + (i % N) * CW + i / N;
            logic [31:0] got = (idx < got_q.size()) ? got_q[idx] : 32'hDEAD_BEEF;
            chk($sformatf("%s[%0d]", tag, i), got, exp);
`ifdef BLOCK_INTERLEAVER_TLAST_EN
            if (idx < got_last_q.size())
                chk($sformatf("%s_last[%0d]", tag, i), got_last_q[idx], (i == BS - 1));
`endif
        end
    endtask

    task automatic check_idle(input string tag);
        repeat (3) @(negedge clk);
        chk(tag, m_axis_tvalid, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b0;
        acc_cnt       = 0;
        rst           = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_s_tready", s_axis_tready, 0);
        chk("rst_m_tvalid", m_axis_tvalid, 0);
        chk("rst_m_tdata", m_axis_tdata, 0);
`ifdef BLOCK_INTERLEAVER_TLAST_EN
        chk("rst_m_tlast", m_axis_tlast, 0);
`endif
        rst = 1'b0;
        #1 chk("rel_tready_pre_edge", s_axis_tready, 0);
        @(negedge clk);
        chk("rel_tready_first_edge", s_axis_tready, 1);

        // Basic order, latency and drain length
        fork
            send(0, BS, 1'b0);
            collect(BS, 1'b0);
        join
        check_block("basic", 0, 0);
        chk("basic_latency", first_vld_cyc - last_hs_cyc, 2);
        chk("basic_drain_len", last_out_cyc - first_vld_cyc, BS - 1);
        check_idle("basic_idle");

        // Output backpressure
        fork
            send(10000, BS, 1'b0);
            collect(BS, 1'b1);
        join
        check_block("bp", 10000, 0);
        m_axis_tready = 1'b1;
        check_idle("bp_idle");

        // Gapped input
        fork
            send(20000, BS, 1'b1);
            collect(BS, 1'b0);
        join
        check_block("gap", 20000, 0);
        check_idle("gap_idle");

        // Ping-pong: three blocks with downstream stalled
        m_axis_tready = 1'b0;
        acc_cnt = 0;
        fork
            send(30000, 3 * BS, 1'b0);
            begin
                int w = 0;
                while (acc_cnt < 2 * BS && w < 5000) begin
                    @(negedge clk);
                    w++;
                end
                repeat (20) @(negedge clk);
                chk("pp_accepted", acc_cnt, 2 * BS);
                chk("pp_s_tready", s_axis_tready, 0);
                chk("pp_m_tvalid", m_axis_tvalid, 1);
                collect(3 * BS, 1'b0);
            end
        join
        check_block("pp0", 30000, 0);
        check_block("pp1", 30000 + BS, 1);
        check_block("pp2", 30000 + 2 * BS, 2);
        check_idle("pp_idle");

        // Reset in the middle of a block
        m_axis_tready = 1'b1;
        send(40000, 100, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_s_tready", s_axis_tready, 0);
        chk("mid_rst_m_tvalid", m_axis_tvalid, 0);
        chk("mid_rst_m_tdata", m_axis_tdata, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rel_s_tready", s_axis_tready, 1);
        chk("mid_rel_m_tvalid", m_axis_tvalid, 0);
        fork
            send(0, BS, 1'b0);
            collect(BS, 1'b0);
        join
        check_block("post_rst", 0, 0);
        chk("post_rst_latency", first_vld_cyc - last_hs_cyc, 2);
        check_idle("post_rst_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
